nucl_mutator: RTL and testbench
===============================

Name: nucl_mutator

Overview:
- Per-lane substitution stage, directly downstream of the record-loading controller that emits one {pos, nucl_alig, matrix_P} record per lane.
- Takes one 16-site, 2-bit-encoded parent alignment chunk and its 4x4 transition-probability matrix.
- Draws one 10-bit pseudo-random number per site and produces the child chunk, one site per cycle.
- Eight instances run in parallel, one per lane.

Parameters:
- SEED, 16'hACE1: LFSR reset value; must be non-zero.
- SITES, 16: nucleotides per chunk; fixed.
- PROB_W, 10: width of each probability entry.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input record valid
- in_ready  out  1  block can accept a record
- pos_in  in  3  lane/position tag
- nucl_in  in  32  parent sites; site k is at [2k+1:2k]; A=0, C=1, G=2, T=3
- matrix_P  in  160  P[i][j] (parent i -> child j) at bits [(4i+j)*10 +: 10]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- pos_out  out  3  pos tag of the record
- nucl_out  out  32  child sites, same layout as nucl_in
- mut_count  out  5  number of sites where child != parent (0..16)

Behaviour:
- States: IDLE, RUN, DONE. A 4-bit site counter cnt.
- Async reset:
  - state = IDLE; cnt = 0; LFSR = SEED.
  - in_ready = 1; out_valid = 0.
  - pos_out = 0; nucl_out = 0; mut_count = 0.
  - Reset during RUN or DONE aborts the record; nothing is emitted.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: latch pos_in, nucl_in and matrix_P; clear nucl_out and mut_count; cnt = 0; go to RUN.
- RUN (in_ready = 0), one site per edge:
  - parent p = latched nucl[2cnt+1:2cnt].
  - r = LFSR[9:0], sampled before the LFSR advances.
  - Effective entry e(j) = P[p][j], except 10'h3FF is treated as 1024 (certainty).
  - Cumulative sums c0 = e(0), c1 = c0 + e(1), c2 = c1 + e(2), computed in 12 bits with no overflow.
  - child = 0 if r < c0; else 1 if r < c1; else 2 if r < c2; else 3.
  - Write child to nucl_out[2cnt+1:2cnt]; mut_count += (child != p).
  - The LFSR advances exactly once per RUN cycle and nowhere else.
  - cnt increments; at the edge processing cnt = 15, go to DONE.
  - Rows summing to less than 1024 leave the residual mass on T; rows summing to more than 1024 are legal, first match wins.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left, feedback = b15^b13^b12^b10 into bit 0. It is not reseeded per record.
- DONE:
  - out_valid = 1; pos_out, nucl_out and mut_count are held stable.
  - On out_ready: go to IDLE and drop out_valid.
  - A new record cannot be accepted in the same cycle.
- Timing:
  - out_valid rises at the 16th edge after the accepting edge.
  - Minimum record period is 18 cycles.
  - Backpressure can last indefinitely with no data change.
- in_valid during RUN or DONE is ignored; the upstream stage must hold the record until in_ready.

Decomposition:
- alisim_pkg holds:
  - constants NUCL_W=2, SITES=16, PROB_W=10, POS_W=3, ALIG_W=32, MAT_W=160;
  - nucleotide enum A/C/G/T;
  - the LFSR tap mask;
  - a function that extracts P[i][j] from the 160-bit matrix.
- One sub-module: lfsr16, with ports clk, reset, advance, q[15:0] and parameter SEED.

Test Plan:
- Identity matrix (P[i][i]=3FF, others 0), nucl_in=32'h1B1B_E4E4, pos_in=5 -> nucl_out=32'h1B1B_E4E4, mut_count=0, pos_out=5; out_valid high exactly 16 edges after acceptance.
- All rows P[i][2]=3FF, others 0, nucl_in=32'h0 -> nucl_out=32'hAAAA_AAAA, mut_count=16.
- All-zero matrix, nucl_in=32'h5555_5555 -> nucl_out=32'hFFFF_FFFF (residual to T), mut_count=16.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid and outputs stable; in_ready=0 throughout; in_valid pulses ignored; record accepted only after return to IDLE.
- Reset asserted at RUN cnt=7 -> all outputs immediately zero, in_ready=1; next identity record matches the first scenario's output and LFSR restarts from SEED. Compare r values against a reference-model LFSR.
- Back-to-back: three records with in_valid held high and out_ready=1 -> three outputs in order, 18-cycle spacing, mut_count correct for each.

Source files
------------

// File: rtl/alisim_pkg.sv
// Shared types and constants for the alignment-simulation substitution stage.
package alisim_pkg;
    localparam int NUCL_W = 2;
    localparam int SITES  = 16;
    localparam int PROB_W = 10;
    localparam int POS_W  = 3;
    localparam int ALIG_W = 32;
    localparam int MAT_W  = 160;

    typedef enum logic [1:0] {NUC_A, NUC_C, NUC_G, NUC_T} nucl_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    // x^16+x^14+x^13+x^11+1 -> taps on bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [ALIG_W-1:0] nucl;
        logic [MAT_W-1:0]  mat;
    } rec_t;

    function automatic logic [PROB_W-1:0] p_entry(input logic [MAT_W-1:0] m,
                                                  input logic [1:0] i,
                                                  input logic [1:0] j);
        return m[(4 * int'(i) + int'(j)) * PROB_W +: PROB_W];
    endfunction
endpackage

// File: rtl/nucl_mutator_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left, feedback into bit 0; steps only when advance is high.
module lfsr16
    import alisim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= SEED;
        else if (advance)
            q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/nucl_mutator.sv
// Per-lane substitution stage: mutates a 16-site parent chunk one site per cycle
// by sampling each site's transition-matrix row with a shared-free LFSR draw.
module nucl_mutator
    import alisim_pkg::*;
#(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          SITES  = 16,
    parameter int          PROB_W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   pos_in,
    input  logic [31:0]  nucl_in,
    input  logic [159:0] matrix_P,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   pos_out,
    output logic [31:0]  nucl_out,
    output logic [4:0]   mut_count
);
    state_e            state_q, state_d;
    logic [3:0]        cnt;
    rec_t              rec_q;
    logic              accept, run;
    logic [15:0]       lfsr_q;
    logic              unused_lfsr_hi;
    nucl_e             parent, child;
    logic [PROB_W-1:0] ent;
    logic [2:0][11:0]  eff;
    logic [11:0]       c0, c1, c2, r;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (run),
        .q       (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[15:PROB_W];
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        run     = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                run = 1'b1;
                if (cnt == 4'(SITES - 1))
                    state_d = ST_DONE;
            end
            ST_DONE: if (out_ready)
                state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // 3FF encodes certainty (1024) so a single-entry row always hits.
    always_comb begin
        parent = nucl_e'(rec_q.nucl[{cnt, 1'b0} +: NUCL_W]);
        ent    = '0;
        eff    = '0;
        for (int j = 0; j < 3; j++) begin
            ent    = p_entry(rec_q.mat, parent, 2'(j));
            eff[j] = (ent == '1) ? 12'd1024 : {2'b00, ent};
        end
        c0 = eff[0];
        c1 = c0 + eff[1];
        c2 = c1 + eff[2];
        r  = {2'b00, lfsr_q[PROB_W-1:0]};
        if (r < c0)      child = NUC_A;
        else if (r < c1) child = NUC_C;
        else if (r < c2) child = NUC_G;
        else             child = NUC_T;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rec_q     <= '0;
            pos_out   <= '0;
            nucl_out  <= '0;
            mut_count <= '0;
        end else if (accept) begin
            cnt       <= '0;
            rec_q     <= '{nucl: nucl_in, mat: matrix_P};
            pos_out   <= pos_in;
            nucl_out  <= '0;
            mut_count <= '0;
        end else if (run) begin
            cnt                          <= cnt + 4'd1;
            nucl_out[{cnt, 1'b0} +: 2]   <= child;
            mut_count                    <= mut_count + {4'b0, child != parent};
        end
    end
endmodule

// File: tb/tb_nucl_mutator.sv
// Scoreboard bench: stimulus pushes expected records, a monitor pops on each output handshake.
module tb_nucl_mutator;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   pos_in, pos_out;
    logic [31:0]  nucl_in, nucl_out;
    logic [159:0] matrix_P;
    logic [4:0]   mut_count;

    nucl_mutator dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .pos_in(pos_in), .nucl_in(nucl_in), .matrix_P(matrix_P),
        .out_valid(out_valid), .out_ready(out_ready),
        .pos_out(pos_out), .nucl_out(nucl_out), .mut_count(mut_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  pos;
        logic [31:0] n;
        logic [4:0]  m;
    } exp_t;

    exp_t        sb[$];
    int          hs_cyc[$];
    int          n_vec = 0, n_err = 0, cyc = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] q);
        logic fb;
        fb = q[15] ^ q[13] ^ q[12] ^ q[10];
        return (q << 1) | {15'd0, fb};
    endfunction

    function automatic logic [159:0] put(input logic [159:0] m, input int i, input int j,
                                         input logic [9:0] v);
        m[(4*i+j)*10 +: 10] = v;
        return m;
    endfunction

    // Reference: walk the row's cumulative distribution with the model LFSR.
    task automatic model(input logic [31:0] n, input logic [159:0] m,
                         output logic [31:0] on, output logic [4:0] om);
        int p, acc, ch, v;
        on = '0;
        om = '0;
        for (int k = 0; k < 16; k++) begin
            p   = int'(n[2*k +: 2]);
            acc = 0;
            ch  = 3;
            for (int j = 2; j >= 0; j--) begin
                acc = 0;
                for (int t = 0; t <= j; t++) begin
                    v   = int'(m[(4*p+t)*10 +: 10]);
                    acc = acc + ((v == 1023) ? 1024 : v);
                end
                if (int'(m_lfsr[9:0]) < acc) ch = j;
            end
            on[2*k +: 2] = 2'(ch);
            if (ch != p) om = om + 5'd1;
            m_lfsr = step(m_lfsr);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] p, input logic [31:0] n, input logic [159:0] m,
                        input bit hold, output logic [31:0] mn, output logic [4:0] mm);
        int t = 0;
        pos_in   = p;
        nucl_in  = n;
        matrix_P = m;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 64'(t < 100), 64'd1);
        @(negedge clk);
        model(n, m, mn, mm);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] p, input logic [31:0] n, input logic [4:0] m);
        exp_t e;
        e.pos = p; e.n = n; e.m = m;
        sb.push_back(e);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_output: got nucl %0h with no expected record", nucl_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pos_out", 64'(pos_out), 64'(e.pos));
                chk("nucl_out", 64'(nucl_out), 64'(e.n));
                chk("mut_count", 64'(mut_count), 64'(e.m));
                hs_cyc.push_back(cyc);
            end
        end
    end

    logic [159:0] m_id, m_g, m_zero, m_mix;
    logic [31:0]  mn;
    logic [4:0]   mm;
    logic [15:0]  ref_q;

    initial begin
        m_id = '0; m_g = '0; m_zero = '0; m_mix = '0;
        for (int i = 0; i < 4; i++) begin
            m_id = put(m_id, i, i, 10'h3FF);
            m_g  = put(m_g, i, 2, 10'h3FF);
        end
        for (int j = 0; j < 4; j++) m_mix = put(m_mix, 0, j, 10'd256);
        m_mix = put(m_mix, 1, 0, 10'd600);
        m_mix = put(m_mix, 1, 1, 10'd600);
        m_mix = put(m_mix, 2, 1, 10'h3FF);
        m_mix = put(m_mix, 3, 0, 10'd100);
        m_mix = put(m_mix, 3, 1, 10'd200);
        m_mix = put(m_mix, 3, 2, 10'd300);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pos_in = '0; nucl_in = '0; matrix_P = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({pos_out, nucl_out, mut_count}), 64'd0);
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        @(negedge clk);

        // identity with latency check
        send(3'd5, 32'h1B1B_E4E4, m_id, 1'b0, mn, mm);
        push(3'd5, 32'h1B1B_E4E4, 5'd0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i >= 15) chk($sformatf("latency_e%0d", i), 64'(out_valid), 64'(i == 16));
        end
        @(negedge clk);

        send(3'd2, 32'h0, m_g, 1'b0, mn, mm);
        push(3'd2, 32'hAAAA_AAAA, 5'd16);
        repeat (18) @(negedge clk);

        send(3'd3, 32'h5555_5555, m_zero, 1'b0, mn, mm);
        push(3'd3, 32'hFFFF_FFFF, 5'd16);
        repeat (18) @(negedge clk);

        send(3'd7, 32'h6C93_D2B4, m_mix, 1'b0, mn, mm);
        push(3'd7, mn, mm);
        repeat (18) @(negedge clk);

        // backpressure in DONE
        out_ready = 1'b0;
        send(3'd6, 32'h1B1B_E4E4, m_id, 1'b0, mn, mm);
        push(3'd6, 32'h1B1B_E4E4, 5'd0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; pos_in = 3'd1; nucl_in = 32'hDEAD_BEEF; matrix_P = m_g;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", 64'({pos_out, nucl_out, mut_count}), 64'({3'd6, 32'h1B1B_E4E4, 5'd0}));
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);

        // reset mid-record at cnt=7
        send(3'd4, 32'h1B1B_E4E4, m_id, 1'b0, mn, mm);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_outputs", 64'({pos_out, nucl_out, mut_count}), 64'd0);
        chk("abort_lfsr", 64'(dut.u_lfsr.q), 64'h0000_0000_0000_ACE1);
        @(negedge clk);
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        @(negedge clk);
        ref_q = m_lfsr;
        send(3'd5, 32'h1B1B_E4E4, m_id, 1'b0, mn, mm);
        push(3'd5, 32'h1B1B_E4E4, 5'd0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("lfsr_site%0d", k), 64'(dut.u_lfsr.q), 64'(ref_q));
            ref_q = step(ref_q);
            @(negedge clk);
        end
        @(negedge clk);

        // back-to-back
        begin
            int base, t;
            base = hs_cyc.size();
            send(3'd1, 32'h1B1B_E4E4, m_id, 1'b1, mn, mm);
            push(3'd1, 32'h1B1B_E4E4, 5'd0);
            send(3'd2, 32'h0, m_g, 1'b1, mn, mm);
            push(3'd2, 32'hAAAA_AAAA, 5'd16);
            send(3'd3, 32'h6C93_D2B4, m_mix, 1'b0, mn, mm);
            push(3'd3, mn, mm);
            t = 0;
            while (sb.size() > 0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            #2;
            if (hs_cyc.size() >= base + 3) begin
                chk("b2b_gap1", 64'(hs_cyc[base+1] - hs_cyc[base]), 64'd18);
                chk("b2b_gap2", 64'(hs_cyc[base+2] - hs_cyc[base+1]), 64'd18);
            end else begin
                chk("b2b_outputs", 64'(hs_cyc.size() - base), 64'd3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
